sdrd_deserializer: RTL

- Sits directly downstream of the CLE109 key-sequencer GAL and consumes the serial bit it drives onto SDRD during qualified reads of the $1xxx window.
- Takes exactly one SDRD sample per qualified read access and assembles WIDTH samples into a parallel word.
- Presents each word to the host-side consumer on a valid/ack handshake, with overrun reporting.
- Resynchronises on stalled transfers (idle timeout) and on any write to the window. The write rule mirrors the GAL: every one of its terms requires BR_W high, so a write returns its state to zero.

---
 rtl/sdrd_deserializer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sdrd_deserializer.sv
// sdrd_deserializer
// Collects the serial bit the CLE109 key-sequencer GAL drives onto SDRD,
// one sample per qualified read of the $1xxx window. WIDTH samples are
// assembled into a parallel word, which is offered to a host-side consumer
// on a valid/ack handshake.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   sser, ba13, ba12    : window decode (sser active low, $1xxx = ~ba13 & ba12)
//   br_w                : 1 = read, 0 = write
//   sdrd                : serial data, captured on the first edge of a read
//   word_data/valid/ack : completed word and its handshake
//   overrun             : sticky, a completed word was dropped while one was pending
//   bit_count           : bits held in the current partial word
//   timeout_pulse       : one-cycle pulse when a stalled partial word is discarded
module sdrd_deserializer #(
  parameter int WIDTH     = 8,
  parameter int TIMEOUT   = 255,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sser,
  input  logic             ba13,
  input  logic             ba12,
  input  logic             br_w,
  input  logic             sdrd,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ack,
  output logic             overrun,
  output logic [4:0]       bit_count,
  output logic             timeout_pulse
);

  localparam int             CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]     CNT_LAST  = 5'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    idle_q, idle_d;
  logic             rd_q;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic             wv_q, wv_d;
  logic             ov_q, ov_d;
  logic             tp_q, tp_d;

  logic             sel, rd_acc, wr_acc, sample, complete;
  logic [WIDTH-1:0] shift_in;

  // Window decode. Only the first edge of a read access is a sample, so a
  // long access contributes exactly one bit.
  assign sel      = ~sser & ~ba13 & ba12;
  assign rd_acc   = sel & br_w;
  assign wr_acc   = sel & ~br_w;
  assign sample   = rd_acc & ~rd_q;
  assign complete = sample & (bit_cnt_q == CNT_LAST);

  // Either direction leaves the first-sampled bit at its final position after
  // WIDTH shifts: bit 0 when shifting right, bit WIDTH-1 when shifting left.
  always_comb begin
    if (MSB_FIRST != 0) shift_in = {sh_q[WIDTH-2:0], sdrd};
    else                shift_in = {sdrd, sh_q[WIDTH-1:1]};
  end

  // State register (all sequential state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      idle_q    <= '0;
      rd_q      <= 1'b0;
      wd_q      <= '0;
      wv_q      <= 1'b0;
      ov_q      <= 1'b0;
      tp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      idle_q    <= idle_d;
      rd_q      <= rd_acc;
      wd_q      <= wd_d;
      wv_q      <= wv_d;
      ov_q      <= ov_d;
      tp_q      <= tp_d;
    end
  end

  // Next-state logic; priority is write > sample > timeout
  always_comb begin
    state_d = state_q;
    if (wr_acc) begin
      state_d = S_IDLE;
    end else if (sample) begin
      state_d = complete ? S_IDLE : S_SHIFT;
    end else if ((state_q == S_SHIFT) && (idle_q == IDLE_LAST)) begin
      state_d = S_IDLE;
    end
  end

  // Datapath / output logic
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    idle_d    = idle_q;
    tp_d      = 1'b0;
    wd_d      = wd_q;
    wv_d      = wv_q;
    ov_d      = ov_q;

    if (wr_acc) begin
      bit_cnt_d = '0;
      sh_d      = '0;
      idle_d    = '0;
    end else if (sample) begin
      idle_d = '0;
      if (complete) begin
        bit_cnt_d = '0;
        sh_d      = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        sh_d      = shift_in;
      end
    end else if (state_q == S_SHIFT) begin
      // The edge on which the counter would reach TIMEOUT discards the word
      if (idle_q == IDLE_LAST) begin
        bit_cnt_d = '0;
        sh_d      = '0;
        idle_d    = '0;
        tp_d      = 1'b1;
      end else begin
        idle_d = idle_q + CW'(1);
      end
    end else begin
      idle_d = '0;
    end

    // An ack on the completion edge frees the slot for the new word
    if (complete) begin
      if (!wv_q || word_ack) begin
        wd_d = shift_in;
        wv_d = 1'b1;
        ov_d = 1'b0;
        if (!wv_q) ov_d = ov_q;
      end else begin
        ov_d = 1'b1;
      end
    end else if (wv_q && word_ack) begin
      wv_d = 1'b0;
      ov_d = 1'b0;
    end
  end

  assign word_data     = wd_q;
  assign word_valid    = wv_q;
  assign overrun       = ov_q;
  assign bit_count     = bit_cnt_q;
  assign timeout_pulse = tp_q;

endmodule
